// File: rtl/regfile_wb_arbiter_if.sv
// Writeback arbiter bus: pipeline/multicycle requests, scoreboard
// lookups and the single registered register-file write port.
interface regfile_wb_arbiter_if;
    logic        p_we;
    logic [4:0]  p_waddr;
    logic [31:0] p_wdata;
    logic        m_valid;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;
    logic        m_ready;
    logic        issue_valid;
    logic [4:0]  issue_addr;
    logic [4:0]  chk_addr1;
    logic [4:0]  chk_addr2;
    logic        hazard1;
    logic        hazard2;
    logic        stall_req;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;

    modport slave (
        input  p_we, p_waddr, p_wdata,
        input  m_valid, m_waddr, m_wdata,
        input  issue_valid, issue_addr,
        input  chk_addr1, chk_addr2,
        output m_ready, hazard1, hazard2,
        output stall_req, we, waddr, wdata
    );

    modport master (
        output p_we, p_waddr, p_wdata,
        output m_valid, m_waddr, m_wdata,
        output issue_valid, issue_addr,
        output chk_addr1, chk_addr2,
        input  m_ready, hazard1, hazard2,
        input  stall_req, we, waddr, wdata
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Single-port register-file writeback arbiter with starvation guard
// and a busy scoreboard for outstanding multicycle destinations.
module regfile_wb_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input logic                 clk,
    input logic                 rst,
    regfile_wb_arbiter_if.slave bus
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic        p_req;
    logic        sat;
    logic        gnt_p;
    logic        gnt_m;
    logic [3:0]  starve_cnt;
    logic [31:1] busy;
    logic [31:0] busy_v;
    logic [31:0] busy_nxt;

    assign p_req  = bus.p_we && (bus.p_waddr != 5'd0);
    assign sat    = (starve_cnt == LIMIT);
    assign busy_v = {busy, 1'b0};

    always_comb begin
        gnt_p = 1'b0;
        gnt_m = 1'b0;
        if (!rst) begin
            case ({p_req, bus.m_valid})
                2'b10:   gnt_p = 1'b1;
                2'b01:   gnt_m = 1'b1;
                2'b11: begin
                    gnt_m = sat;
                    gnt_p = !sat;
                end
                default: ;
            endcase
        end
    end

    assign bus.m_ready   = gnt_m;
    assign bus.stall_req = !rst && p_req && !gnt_p;
    assign bus.hazard1   = !rst && busy_v[bus.chk_addr1];
    assign bus.hazard2   = !rst && busy_v[bus.chk_addr2];

    // A same-cycle issue wins over the retiring write to the same register.
    always_comb begin
        busy_nxt = busy_v;
        if (gnt_m)
            busy_nxt[bus.m_waddr] = 1'b0;
        if (bus.issue_valid)
            busy_nxt[bus.issue_addr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.we     <= 1'b0;
            bus.waddr  <= 5'd0;
            bus.wdata  <= 32'd0;
            busy       <= '0;
            starve_cnt <= 4'd0;
        end else begin
            busy <= busy_nxt[31:1];
            if (gnt_p) begin
                bus.we    <= 1'b1;
                bus.waddr <= bus.p_waddr;
                bus.wdata <= bus.p_wdata;
            end else if (gnt_m && bus.m_waddr != 5'd0) begin
                bus.we    <= 1'b1;
                bus.waddr <= bus.m_waddr;
                bus.wdata <= bus.m_wdata;
            end else begin
                bus.we <= 1'b0;
            end
            if (bus.m_valid && !gnt_m)
                starve_cnt <= sat ? starve_cnt : starve_cnt + 4'd1;
            else
                starve_cnt <= 4'd0;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for the writeback arbiter: arbitration, starvation,
// scoreboard hazards, zero-register cases and mid-contention reset.
module tb_regfile_wb_arbiter;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    regfile_wb_arbiter_if bus ();

    regfile_wb_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.p_we        = 1'b0;
        bus.p_waddr     = 5'd0;
        bus.p_wdata     = 32'd0;
        bus.m_valid     = 1'b0;
        bus.m_waddr     = 5'd0;
        bus.m_wdata     = 32'd0;
        bus.issue_valid = 1'b0;
        bus.issue_addr  = 5'd0;
        bus.chk_addr1   = 5'd0;
        bus.chk_addr2   = 5'd0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        bus.p_we    = 1'b1;
        bus.p_waddr = 5'd2;
        bus.m_valid = 1'b1;
        bus.m_waddr = 5'd3;
        step();
        step();
        checks++;
        if (bus.we !== 1'b0) begin
            errors++;
            $display("FAIL reset_we: got %0b want 0", bus.we);
        end
        checks++;
        if (bus.waddr !== 5'd0 || bus.wdata !== 32'd0) begin
            errors++;
            $display("FAIL reset_wport: got %0d/%0h want 0/0",
                     bus.waddr, bus.wdata);
        end
        checks++;
        if (bus.stall_req !== 1'b0 || bus.m_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_comb: got stall=%0b rdy=%0b want 0/0",
                     bus.stall_req, bus.m_ready);
        end
        idle();
        rst = 1'b0;
        step();
    endtask

    task automatic test_pipe_write();
        bus.p_we    = 1'b1;
        bus.p_waddr = 5'd3;
        bus.p_wdata = 32'h11;
        #1;
        checks++;
        if (bus.stall_req !== 1'b0) begin
            errors++;
            $display("FAIL pipe_stall: got %0b want 0", bus.stall_req);
        end
        step();
        idle();
        checks++;
        if (bus.we !== 1'b1 || bus.waddr !== 5'd3 || bus.wdata !== 32'h11) begin
            errors++;
            $display("FAIL pipe_write: got %0b/%0d/%0h want 1/3/11",
                     bus.we, bus.waddr, bus.wdata);
        end
        step();
        checks++;
        if (bus.we !== 1'b0 || bus.waddr !== 5'd3 || bus.wdata !== 32'h11) begin
            errors++;
            $display("FAIL pipe_hold: got %0b/%0d/%0h want 0/3/11",
                     bus.we, bus.waddr, bus.wdata);
        end
    endtask

    task automatic test_starve();
        logic       exp_m;
        logic [4:0] exp_a;
        bus.p_we    = 1'b1;
        bus.p_waddr = 5'd5;
        bus.p_wdata = 32'hA5;
        bus.m_valid = 1'b1;
        bus.m_waddr = 5'd7;
        bus.m_wdata = 32'h77;
        for (int c = 1; c <= 5; c++) begin
            #1;
            exp_m = (c == 5);
            exp_a = (c == 5) ? 5'd7 : 5'd5;
            checks++;
            if (bus.m_ready !== exp_m || bus.stall_req !== exp_m) begin
                errors++;
                $display("FAIL starve_c%0d: got rdy=%0b stall=%0b want %0b/%0b",
                         c, bus.m_ready, bus.stall_req, exp_m, exp_m);
            end
            step();
            if (c == 5) idle();
            checks++;
            if (bus.we !== 1'b1 || bus.waddr !== exp_a) begin
                errors++;
                $display("FAIL starve_w%0d: got %0b/%0d want 1/%0d",
                         c, bus.we, bus.waddr, exp_a);
            end
        end
        checks++;
        if (dut.starve_cnt !== 4'd0) begin
            errors++;
            $display("FAIL starve_clr: got %0d want 0", dut.starve_cnt);
        end
        step();
    endtask

    task automatic test_hazard();
        bus.issue_valid = 1'b1;
        bus.issue_addr  = 5'd9;
        bus.chk_addr1   = 5'd9;
        #1;
        checks++;
        if (bus.hazard1 !== 1'b0) begin
            errors++;
            $display("FAIL haz_nofwd: got %0b want 0", bus.hazard1);
        end
        step();
        bus.issue_valid = 1'b0;
        #1;
        checks++;
        if (bus.hazard1 !== 1'b1 || bus.hazard2 !== 1'b0) begin
            errors++;
            $display("FAIL haz_set: got %0b/%0b want 1/0",
                     bus.hazard1, bus.hazard2);
        end
        bus.m_valid = 1'b1;
        bus.m_waddr = 5'd9;
        bus.m_wdata = 32'h99;
        #1;
        checks++;
        if (bus.m_ready !== 1'b1 || bus.hazard1 !== 1'b1) begin
            errors++;
            $display("FAIL haz_acc: got rdy=%0b haz=%0b want 1/1",
                     bus.m_ready, bus.hazard1);
        end
        step();
        idle();
        bus.chk_addr1 = 5'd9;
        #1;
        checks++;
        if (bus.hazard1 !== 1'b0) begin
            errors++;
            $display("FAIL haz_clr: got %0b want 0", bus.hazard1);
        end
        checks++;
        if (bus.we !== 1'b1 || bus.waddr !== 5'd9 || bus.wdata !== 32'h99) begin
            errors++;
            $display("FAIL haz_mw: got %0b/%0d/%0h want 1/9/99",
                     bus.we, bus.waddr, bus.wdata);
        end
    endtask

    task automatic test_set_clear();
        idle();
        bus.issue_valid = 1'b1;
        bus.issue_addr  = 5'd9;
        step();
        bus.m_valid = 1'b1;
        bus.m_waddr = 5'd9;
        bus.m_wdata = 32'h19;
        step();
        idle();
        bus.chk_addr2 = 5'd9;
        #1;
        checks++;
        if (bus.hazard2 !== 1'b1) begin
            errors++;
            $display("FAIL setclr_keep: got %0b want 1", bus.hazard2);
        end
        bus.m_valid = 1'b1;
        bus.m_waddr = 5'd9;
        step();
        idle();
        bus.chk_addr2 = 5'd9;
        #1;
        checks++;
        if (bus.hazard2 !== 1'b0) begin
            errors++;
            $display("FAIL setclr_clr: got %0b want 0", bus.hazard2);
        end
    endtask

    task automatic test_zero_reg();
        idle();
        bus.issue_valid = 1'b1;
        bus.issue_addr  = 5'd12;
        step();
        idle();
        bus.p_we      = 1'b1;
        bus.m_valid   = 1'b1;
        bus.m_wdata   = 32'hDEAD;
        bus.chk_addr1 = 5'd12;
        #1;
        checks++;
        if (bus.stall_req !== 1'b0 || bus.m_ready !== 1'b1) begin
            errors++;
            $display("FAIL zero_comb: got stall=%0b rdy=%0b want 0/1",
                     bus.stall_req, bus.m_ready);
        end
        step();
        idle();
        bus.chk_addr1 = 5'd12;
        #1;
        checks++;
        if (bus.we !== 1'b0 || bus.hazard1 !== 1'b1) begin
            errors++;
            $display("FAIL zero_we: got we=%0b haz=%0b want 0/1",
                     bus.we, bus.hazard1);
        end
        bus.p_we    = 1'b1;
        bus.p_waddr = 5'd12;
        bus.p_wdata = 32'h12;
        step();
        idle();
        bus.chk_addr1 = 5'd12;
        #1;
        checks++;
        if (bus.we !== 1'b1 || bus.waddr !== 5'd12 || bus.hazard1 !== 1'b1) begin
            errors++;
            $display("FAIL busy_pwr: got %0b/%0d haz=%0b want 1/12/1",
                     bus.we, bus.waddr, bus.hazard1);
        end
        bus.m_valid = 1'b1;
        bus.m_waddr = 5'd12;
        step();
        idle();
    endtask

    task automatic test_reset_mid();
        idle();
        bus.issue_valid = 1'b1;
        bus.issue_addr  = 5'd4;
        step();
        idle();
        bus.p_we    = 1'b1;
        bus.p_waddr = 5'd5;
        bus.m_valid = 1'b1;
        bus.m_waddr = 5'd7;
        repeat (3) step();
        checks++;
        if (dut.starve_cnt !== 4'd3 || dut.busy[4] !== 1'b1) begin
            errors++;
            $display("FAIL rmid_pre: got cnt=%0d b4=%0b want 3/1",
                     dut.starve_cnt, dut.busy[4]);
        end
        rst = 1'b1;
        bus.issue_valid = 1'b1;
        bus.issue_addr  = 5'd6;
        bus.chk_addr1   = 5'd4;
        #1;
        checks++;
        if (bus.m_ready !== 1'b0 || bus.stall_req !== 1'b0 ||
            bus.hazard1 !== 1'b0) begin
            errors++;
            $display("FAIL rmid_comb: got %0b/%0b/%0b want 0/0/0",
                     bus.m_ready, bus.stall_req, bus.hazard1);
        end
        step();
        checks++;
        if (bus.we !== 1'b0 || dut.busy !== 31'd0 || dut.starve_cnt !== 4'd0) begin
            errors++;
            $display("FAIL rmid_rst: got we=%0b busy=%0h cnt=%0d want 0/0/0",
                     bus.we, dut.busy, dut.starve_cnt);
        end
        rst = 1'b0;
        bus.issue_valid = 1'b0;
        bus.chk_addr2   = 5'd6;
        #1;
        checks++;
        if (bus.m_ready !== 1'b0 || bus.stall_req !== 1'b0 ||
            bus.hazard2 !== 1'b0) begin
            errors++;
            $display("FAIL rmid_resume: got %0b/%0b/%0b want 0/0/0",
                     bus.m_ready, bus.stall_req, bus.hazard2);
        end
        step();
        idle();
        checks++;
        if (bus.we !== 1'b1 || bus.waddr !== 5'd5) begin
            errors++;
            $display("FAIL rmid_win: got %0b/%0d want 1/5", bus.we, bus.waddr);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        idle();
        test_reset();
        test_pipe_write();
        test_starve();
        test_hazard();
        test_set_clear();
        test_zero_reg();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
